// File: rtl/rs232_pkg.sv
// Shared constants for the tx_rs232 arbiter slice:
// FSM state encodings, default byte width and watchdog sizing.
package rs232_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int RS232_DATA_W = 8;

    // Watchdog counter width; counts 0..timeout_cyc-1.
    function automatic int cnt_w(input int timeout_cyc);
        return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or
// after the pointer, wrapping; returns one-hot grant and index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Scan offsets from farthest to nearest so the nearest wins.
    always_comb begin
        int k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(i_ptr) + i) % N;
            if (i_req[k]) begin
                o_grant = N'(1) << k;
                o_idx   = IW'(k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin sharing of one tx_rs232 serializer among byte
// producers, with launch pulse, completion report and watchdog.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = RS232_DATA_W,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                       clk_s,
    input  logic                       rstn_s,
    input  logic [NUM_REQ-1:0]         iREQ,
    input  logic [NUM_REQ*DATA_W-1:0]  iREQ_DATA,
    output logic [NUM_REQ-1:0]         oGRANT,
    output logic [NUM_REQ-1:0]         oDONE,
    output logic                       oTX_SEND,
    output logic [DATA_W-1:0]          oTX_DATA,
    input  logic                       iTX_FINISH,
    output logic                       oBUSY,
    output logic [$clog2(NUM_REQ)-1:0] oOWNER,
    output logic                       oTIMEOUT
);

    localparam int OW    = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_w(TIMEOUT_CYC);

    logic [1:0]         r_state;
    logic [OW-1:0]      r_ptr;
    logic [OW-1:0]      r_owner;
    logic [CNT_W-1:0]   r_wdog;
    logic [DATA_W-1:0]  r_data;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_send;
    logic               r_busy;
    logic               r_timeout;

    logic [NUM_REQ-1:0] w_pick;
    logic [OW-1:0]      w_idx;
    logic               w_valid;
    logic [DATA_W-1:0]  w_byte;
    logic [NUM_REQ-1:0] w_owner_hot;
    logic [OW-1:0]      w_next_ptr;
    logic               w_launch;
    logic               w_finish;
    logic               w_expire;
    logic               w_end;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_rr (
        .i_req   (iREQ),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_byte      = iREQ_DATA[w_idx*DATA_W +: DATA_W];
    assign w_owner_hot = NUM_REQ'(1) << r_owner;
    assign w_next_ptr  = (r_owner == OW'(NUM_REQ - 1)) ?
                         '0 : r_owner + OW'(1);

    // Finish has priority over the watchdog in the same cycle.
    assign w_launch = (r_state == ST_IDLE) && w_valid;
    assign w_finish = (r_state == ST_WAIT) && iTX_FINISH;
    assign w_expire = (r_state == ST_WAIT) && !iTX_FINISH &&
                      (r_wdog == CNT_W'(TIMEOUT_CYC - 1));
    assign w_end    = w_finish || w_expire;

    // State sequencing IDLE -> SEND -> WAIT -> IDLE.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_launch) r_state <= ST_SEND;
                ST_SEND: r_state <= ST_WAIT;
                ST_WAIT: if (w_end) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle pulses: launch, grant, done and timeout.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_send    <= 1'b0;
            r_grant   <= '0;
            r_done    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_send    <= w_launch;
            r_grant   <= w_launch ? w_pick : '0;
            r_done    <= w_finish ? w_owner_hot : '0;
            r_timeout <= w_expire;
        end
    end

    // Busy spans launch until done or watchdog expiry.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_busy <= 1'b0;
        end else if (w_launch) begin
            r_busy <= 1'b1;
        end else if (w_end) begin
            r_busy <= 1'b0;
        end
    end

    // Captured byte and owner; byte returns to zero when idle.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_data  <= '0;
            r_owner <= '0;
        end else if (w_launch) begin
            r_data  <= w_byte;
            r_owner <= w_idx;
        end else if (w_end) begin
            r_data  <= '0;
        end
    end

    // Watchdog counts clk_s cycles since the launch pulse.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_wdog <= '0;
        end else if (r_state == ST_SEND) begin
            r_wdog <= CNT_W'(1);
        end else if (r_state == ST_WAIT && !w_end) begin
            r_wdog <= r_wdog + CNT_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end

    // Pointer moves past the owner once its frame ends.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_ptr <= '0;
        end else if (w_end) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign oGRANT   = r_grant;
    assign oDONE    = r_done;
    assign oTX_SEND = r_send;
    assign oTX_DATA = r_data;
    assign oBUSY    = r_busy;
    assign oOWNER   = r_owner;
    assign oTIMEOUT = r_timeout;

endmodule
